// File: rtl/vga_frame_sched.sv
// Raster timing generator for the 1024x768@60 VGA pipeline, plus the per-frame
// update-window handshake with the game logic (opens at vblank, closes at frame wrap).
module vga_frame_sched #(
    parameter int HOR_TOTAL_TIME  = 1344,
    parameter int HOR_BLANK_START = 1024,
    parameter int HOR_SYNC_START  = 1048,
    parameter int HOR_SYNC_STOP   = 1184,
    parameter int VER_TOTAL_TIME  = 806,
    parameter int VER_BLANK_START = 768,
    parameter int VER_SYNC_START  = 771,
    parameter int VER_SYNC_STOP   = 777
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start,
    output logic        upd_req,
    input  logic        upd_done,
    output logic        overrun,
    output logic [15:0] frame_cnt,
    output logic [7:0]  overrun_cnt
);

    localparam logic [10:0] H_LAST     = 11'(HOR_TOTAL_TIME - 1);
    localparam logic [10:0] H_BLANK    = 11'(HOR_BLANK_START);
    localparam logic [10:0] H_SYNC_ON  = 11'(HOR_SYNC_START);
    localparam logic [10:0] H_SYNC_OFF = 11'(HOR_SYNC_STOP);
    localparam logic [10:0] V_LAST     = 11'(VER_TOTAL_TIME - 1);
    localparam logic [10:0] V_BLANK    = 11'(VER_BLANK_START);
    localparam logic [10:0] V_SYNC_ON  = 11'(VER_SYNC_START);
    localparam logic [10:0] V_SYNC_OFF = 11'(VER_SYNC_STOP);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;
    logic        upd_req_q, upd_req_d;
    logic        overrun_q, overrun_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  overrun_cnt_q, overrun_cnt_d;
    logic        deadline;

    // Every flag is decoded from the *next* position so that, once registered,
    // it lines up with hcount/vcount in the same cycle.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end

        hsync_d       = (hcount_d >= H_SYNC_ON) && (hcount_d < H_SYNC_OFF);
        vsync_d       = (vcount_d >= V_SYNC_ON) && (vcount_d < V_SYNC_OFF);
        hblnk_d       = (hcount_d >= H_BLANK);
        vblnk_d       = (vcount_d >= V_BLANK);
        frame_start_d = (hcount_d == 11'd0) && (vcount_d == V_BLANK);
        deadline      = (hcount_d == 11'd0) && (vcount_d == 11'd0);

        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        state_d       = state_q;
        upd_req_d     = upd_req_q;
        overrun_d     = 1'b0;
        overrun_cnt_d = overrun_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start_d) begin
                    state_d   = ST_REQ;
                    upd_req_d = 1'b1;
                end
            end
            ST_REQ: begin
                // A done pulse landing on the frame_start cycle itself is stale.
                if (upd_done && !frame_start_q) begin
                    state_d   = deadline ? ST_IDLE : ST_DONE;
                    upd_req_d = 1'b0;
                end else if (deadline) begin
                    state_d   = ST_IDLE;
                    upd_req_d = 1'b0;
                    overrun_d = 1'b1;
                    if (overrun_cnt_q != 8'hFF) begin
                        overrun_cnt_d = overrun_cnt_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                if (deadline) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                upd_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            upd_req_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            upd_req_q     <= upd_req_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign frame_start = frame_start_q;
    assign upd_req     = upd_req_q;
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_vga_frame_sched.sv
// Bench: full-size raster checked over one line; a shrunken raster (16x12, 192 clk/frame)
// carries the frame-level handshake, overrun saturation and reset scenarios.
module tb_vga_frame_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small raster instance
    logic        rst, upd_done;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, hblnk, vblnk, frame_start, upd_req, overrun;
    logic [15:0] frame_cnt;
    logic [7:0]  overrun_cnt;

    // Full-size instance, line timing only
    logic        f_rst, f_upd_done;
    logic [10:0] f_hcount, f_vcount;
    logic        f_hsync, f_vsync, f_hblnk, f_vblnk, f_frame_start, f_upd_req, f_overrun;
    logic [15:0] f_frame_cnt;
    logic [7:0]  f_overrun_cnt;

    vga_frame_sched #(
        .HOR_TOTAL_TIME(16), .HOR_BLANK_START(12), .HOR_SYNC_START(13), .HOR_SYNC_STOP(15),
        .VER_TOTAL_TIME(12), .VER_BLANK_START(8),  .VER_SYNC_START(9),  .VER_SYNC_STOP(11)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
        .frame_start(frame_start), .upd_req(upd_req), .upd_done(upd_done),
        .overrun(overrun), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
    );

    vga_frame_sched dut_full (
        .clk(clk), .rst(f_rst), .hcount(f_hcount), .vcount(f_vcount),
        .hsync(f_hsync), .vsync(f_vsync), .hblnk(f_hblnk), .vblnk(f_vblnk),
        .frame_start(f_frame_start), .upd_req(f_upd_req), .upd_done(f_upd_done),
        .overrun(f_overrun), .frame_cnt(f_frame_cnt), .overrun_cnt(f_overrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Free-running cycle count and per-frame window statistics, sampled on negedge
    int tb_cyc = 0;
    int fs_time = 0, fs_prev = 0;
    int vs_acc = 0, vb_acc = 0, vs_last = 0, vb_last = 0;
    int ov_pulses = 0;
    always @(posedge clk) tb_cyc++;
    always @(negedge clk) begin
        if (overrun) ov_pulses++;
        if (frame_start) begin
            fs_prev = fs_time;
            fs_time = tb_cyc;
            vs_last = vs_acc;
            vb_last = vb_acc;
            vs_acc  = 0;
            vb_acc  = 0;
        end
        if (vsync) vs_acc++;
        if (vblnk) vb_acc++;
    end

    typedef struct {
        int n;
        int h;
        int v;
        bit hs, vs, hb, vb, fs, req, ov;
        int fc;
        int oc;
    } vec_t;

    function automatic vec_t mk(int n, int h, int v, bit hs, bit vs, bit hb, bit vb,
                                bit fs, bit req, bit ov, int fc, int oc);
        vec_t r;
        r.n = n; r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.hb = hb; r.vb = vb;
        r.fs = fs; r.req = req; r.ov = ov; r.fc = fc; r.oc = oc;
        return r;
    endfunction

    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (hcount == 11'(h) && vcount == 11'(v)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_fs(output int n);
        n = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (frame_start) begin
                n = i;
                return;
            end
        end
    endtask

    vec_t ftab[9];
    vec_t stab[15];

    initial begin
        bit ok;
        int n, cyc, ov0;

        // n = cycles after reset release; full raster, first line
        ftab[0] = mk(0,    0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ftab[1] = mk(1023, 1023, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ftab[2] = mk(1024, 1024, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        ftab[3] = mk(1047, 1047, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        ftab[4] = mk(1048, 1048, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        ftab[5] = mk(1183, 1183, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        ftab[6] = mk(1184, 1184, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        ftab[7] = mk(1343, 1343, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        ftab[8] = mk(1344, 0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // small raster, first frame with no upd_done at all
        stab[0]  = mk(0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        stab[1]  = mk(11,  11, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        stab[2]  = mk(12,  12, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
        stab[3]  = mk(13,  13, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0);
        stab[4]  = mk(15,  15, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
        stab[5]  = mk(16,  0,  1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        stab[6]  = mk(127, 15, 7,  0, 0, 1, 0, 0, 0, 0, 0, 0);
        stab[7]  = mk(128, 0,  8,  0, 0, 0, 1, 1, 1, 0, 1, 0);
        stab[8]  = mk(129, 1,  8,  0, 0, 0, 1, 0, 1, 0, 1, 0);
        stab[9]  = mk(144, 0,  9,  0, 1, 0, 1, 0, 1, 0, 1, 0);
        stab[10] = mk(172, 12, 10, 0, 1, 1, 1, 0, 1, 0, 1, 0);
        stab[11] = mk(176, 0,  11, 0, 0, 0, 1, 0, 1, 0, 1, 0);
        stab[12] = mk(191, 15, 11, 0, 0, 1, 1, 0, 1, 0, 1, 0);
        stab[13] = mk(192, 0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 1);
        stab[14] = mk(193, 1,  0,  0, 0, 0, 0, 0, 0, 0, 1, 1);

        rst = 1'b1; f_rst = 1'b1; upd_done = 1'b0; f_upd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 f_rst = 1'b0;

        cyc = 0;
        foreach (ftab[i]) begin
            while (cyc < ftab[i].n) begin
                @(posedge clk); #1;
                cyc++;
            end
            $display("full vec %0d n=%0d h=%0d v=%0d hs=%0d hb=%0d", i, cyc, f_hcount, f_vcount, f_hsync, f_hblnk);
            chk($sformatf("full%0d hcount", i), 32'(f_hcount), ftab[i].h);
            chk($sformatf("full%0d vcount", i), 32'(f_vcount), ftab[i].v);
            chk($sformatf("full%0d hsync", i), 32'(f_hsync), 32'(ftab[i].hs));
            chk($sformatf("full%0d hblnk", i), 32'(f_hblnk), 32'(ftab[i].hb));
            chk($sformatf("full%0d vsync", i), 32'(f_vsync), 32'(ftab[i].vs));
            chk($sformatf("full%0d vblnk", i), 32'(f_vblnk), 32'(ftab[i].vb));
            chk($sformatf("full%0d frame_start", i), 32'(f_frame_start), 32'(ftab[i].fs));
        end

        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        foreach (stab[i]) begin
            while (cyc < stab[i].n) begin
                @(posedge clk); #1;
                cyc++;
            end
            $display("small vec %0d n=%0d h=%0d v=%0d req=%0d ov=%0d fc=%0d oc=%0d",
                     i, cyc, hcount, vcount, upd_req, overrun, frame_cnt, overrun_cnt);
            chk($sformatf("v%0d hcount", i), 32'(hcount), stab[i].h);
            chk($sformatf("v%0d vcount", i), 32'(vcount), stab[i].v);
            chk($sformatf("v%0d hsync", i), 32'(hsync), 32'(stab[i].hs));
            chk($sformatf("v%0d vsync", i), 32'(vsync), 32'(stab[i].vs));
            chk($sformatf("v%0d hblnk", i), 32'(hblnk), 32'(stab[i].hb));
            chk($sformatf("v%0d vblnk", i), 32'(vblnk), 32'(stab[i].vb));
            chk($sformatf("v%0d frame_start", i), 32'(frame_start), 32'(stab[i].fs));
            chk($sformatf("v%0d upd_req", i), 32'(upd_req), 32'(stab[i].req));
            chk($sformatf("v%0d overrun", i), 32'(overrun), 32'(stab[i].ov));
            chk($sformatf("v%0d frame_cnt", i), 32'(frame_cnt), stab[i].fc);
            chk($sformatf("v%0d overrun_cnt", i), 32'(overrun_cnt), stab[i].oc);
        end

        // Frame 2: done on the frame_start cycle is ignored, a later done closes the window
        wait_fs(n);
        chk("frame2 fs timeout", 32'(n >= 0), 1);
        chk("frame2 frame_cnt", 32'(frame_cnt), 2);
        upd_done = 1'b1;
        @(posedge clk); #1 upd_done = 1'b0;
        $display("seq done@frame_start req=%0d", upd_req);
        chk("done@fs upd_req held", 32'(upd_req), 1);
        chk("frame period", 32'(fs_time - fs_prev), 192);
        chk("vsync cycles per frame", 32'(vs_last), 32);
        chk("vblnk cycles per frame", 32'(vb_last), 64);
        repeat (8) @(posedge clk);
        #1 upd_done = 1'b1;
        chk("pre-done upd_req", 32'(upd_req), 1);
        @(posedge clk); #1 upd_done = 1'b0;
        $display("seq done mid-window req=%0d ov=%0d", upd_req, overrun);
        chk("done upd_req falls", 32'(upd_req), 0);
        chk("done overrun", 32'(overrun), 0);
        ov0 = ov_pulses;
        wait_pos(0, 0, ok);
        chk("frame2 deadline timeout", 32'(ok), 1);
        $display("seq frame2 deadline ov=%0d oc=%0d", overrun, overrun_cnt);
        chk("frame2 deadline overrun", 32'(overrun), 0);
        chk("frame2 overrun_cnt", 32'(overrun_cnt), 1);
        chk("frame2 no overrun pulses", 32'(ov_pulses - ov0), 0);

        // Frame 3: done in the cycle that reaches the deadline
        wait_pos(15, 11, ok);
        chk("frame3 last pixel timeout", 32'(ok), 1);
        chk("frame3 upd_req open", 32'(upd_req), 1);
        upd_done = 1'b1;
        @(posedge clk); #1 upd_done = 1'b0;
        $display("seq done@deadline h=%0d v=%0d req=%0d ov=%0d", hcount, vcount, upd_req, overrun);
        chk("done@deadline hcount", 32'(hcount), 0);
        chk("done@deadline upd_req", 32'(upd_req), 0);
        chk("done@deadline overrun", 32'(overrun), 0);
        chk("done@deadline overrun_cnt", 32'(overrun_cnt), 1);

        // 300 more frames without done: saturation at 255
        repeat (300 * 192) @(posedge clk);
        #1;
        $display("seq saturate fc=%0d oc=%0d ov=%0d", frame_cnt, overrun_cnt, overrun);
        chk("sat frame_cnt", 32'(frame_cnt), 303);
        chk("sat overrun_cnt", 32'(overrun_cnt), 255);
        chk("sat overrun pulse", 32'(overrun), 1);

        // Reset in the middle of active video
        wait_pos(0, 5, ok);
        chk("mid-frame pos timeout", 32'(ok), 1);
        rst = 1'b1;
        #1;
        $display("seq async reset h=%0d v=%0d fc=%0d oc=%0d", hcount, vcount, frame_cnt, overrun_cnt);
        chk("rst hcount", 32'(hcount), 0);
        chk("rst vcount", 32'(vcount), 0);
        chk("rst frame_cnt", 32'(frame_cnt), 0);
        chk("rst overrun_cnt", 32'(overrun_cnt), 0);
        chk("rst upd_req", 32'(upd_req), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_fs(n);
        $display("seq post-reset frame_start after %0d clk fc=%0d", n, frame_cnt);
        chk("post-reset fs latency", 32'(n), 128);
        chk("post-reset frame_cnt", 32'(frame_cnt), 1);
        chk("post-reset upd_req", 32'(upd_req), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
